// File: rtl/mano_cpu_param_if.sv
// Host-side bus of the basic-computer core: start control, memory
// load/readback port and the INPR/OUTR character handshakes.
interface mano_cpu_param_if #(
  parameter int ADDR_W = 12,
  parameter int MEM_AW = 8
);
  localparam int DW = ADDR_W + 4;

  logic              start;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output start, mem_we, mem_addr, mem_wdata, in_data, in_valid, out_ready,
    input  mem_rdata, in_ready, out_data, out_valid
  );

  modport slave (
    input  start, mem_we, mem_addr, mem_wdata, in_data, in_valid, out_ready,
    output mem_rdata, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mano_cpu_param.sv
// Parametrised basic-computer CPU: T-state sequenced fetch/decode/execute,
// interrupt cycle, INPR/OUTR I/O flags and a host load port while halted.
module mano_cpu_param #(
  parameter int ADDR_W = 12,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  mano_cpu_param_if.slave   bus,
  output logic              running,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W+3:0] ac,
  output logic [ADDR_W+3:0] ir,
  output logic              e,
  output logic [3:0]        sc
);
  localparam int DW = ADDR_W + 4;
  localparam int MW = 1 << MEM_AW;
  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]     D_ONE = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5, T6 = 4'd6
  } tstate_e;

  tstate_e           t;
  logic              s, r, ind, e_q, ien, fgi, fgo;
  logic [ADDR_W-1:0] pc_q, ar;
  logic [DW-1:0]     ir_q, tr, dr, ac_q;
  logic [7:0]        inpr, outr;
  logic [DW-1:0]     mem [MW];

  logic [DW-1:0]     mrd;
  logic [2:0]        op;
  logic [11:0]       b;
  logic              we;
  logic [MEM_AW-1:0] wa;
  logic [DW-1:0]     wd;

  assign mrd = mem[ar[MEM_AW-1:0]];
  assign op  = ir_q[DW-2:DW-4];
  assign b   = ar[ADDR_W-1 -: 12];

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.in_ready  = ~fgi;
  assign bus.out_data  = outr;
  assign bus.out_valid = ~fgo;
  assign running = s;
  assign pc      = pc_q;
  assign ac      = ac_q;
  assign ir      = ir_q;
  assign e       = e_q;
  assign sc      = t;

  // Select the single memory write source for this cycle (host or CPU).
  always_comb begin
    we = 1'b0;
    wa = ar[MEM_AW-1:0];
    wd = ac_q;
    if (!s) begin
      we = bus.mem_we;
      wa = bus.mem_addr;
      wd = bus.mem_wdata;
    end else if (r && t == T1) begin
      we = 1'b1;
      wd = tr;
    end else if (op != 3'd7) begin
      if (t == T4 && op == 3'd3) begin
        we = 1'b1;
      end else if (t == T4 && op == 3'd5) begin
        we = 1'b1;
        wd = {4'b0, pc_q};
      end else if (t == T6 && op == 3'd6) begin
        we = 1'b1;
        wd = dr;
      end
    end
  end

  // Memory array; the reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && we) mem[wa] <= wd;
  end

  // Timing-state machine, register transfers and I/O flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= 1'b0;
      t    <= T0;
      pc_q <= '0;
      ar   <= '0;
      ir_q <= '0;
      tr   <= '0;
      dr   <= '0;
      ac_q <= '0;
      ind  <= 1'b0;
      e_q  <= 1'b0;
      ien  <= 1'b0;
      r    <= 1'b0;
      fgi  <= 1'b0;
      fgo  <= 1'b1;
      inpr <= '0;
      outr <= '0;
    end else begin
      // Handshakes first so a same-edge CPU clear below takes precedence.
      if (bus.in_valid && !fgi) begin
        inpr <= bus.in_data;
        fgi  <= 1'b1;
      end
      if (!fgo && bus.out_ready) fgo <= 1'b1;

      if (!s) begin
        if (bus.start) s <= 1'b1;
      end else begin
        t <= tstate_e'(t + 4'd1);
        case (t)
          T0: begin
            if (r) begin
              ar <= '0;
              tr <= {4'b0, pc_q};
            end else begin
              ar <= pc_q;
            end
          end
          T1: begin
            if (r) begin
              pc_q <= '0;
            end else begin
              ir_q <= mrd;
              pc_q <= pc_q + A_ONE;
            end
          end
          T2: begin
            if (r) begin
              pc_q <= A_ONE;
              ien  <= 1'b0;
              r    <= 1'b0;
              t    <= T0;
            end else begin
              ar  <= ir_q[ADDR_W-1:0];
              ind <= ir_q[DW-1];
            end
          end
          default: begin
            if (ien && (fgi || fgo)) r <= 1'b1;
            if (op == 3'd7) begin
              t <= T0;
              if (!ind) begin
                if (b[11])      ac_q <= '0;
                else if (b[10]) e_q <= 1'b0;
                else if (b[9])  ac_q <= ~ac_q;
                else if (b[8])  e_q <= ~e_q;
                else if (b[7])  {ac_q, e_q} <= {e_q, ac_q};
                else if (b[6])  {e_q, ac_q} <= {ac_q, e_q};
                else if (b[5])  ac_q <= ac_q + D_ONE;
                else if (b[4])  begin if (!ac_q[DW-1]) pc_q <= pc_q + A_ONE; end
                else if (b[3])  begin if (ac_q[DW-1]) pc_q <= pc_q + A_ONE; end
                else if (b[2])  begin if (ac_q == '0) pc_q <= pc_q + A_ONE; end
                else if (b[1])  begin if (!e_q) pc_q <= pc_q + A_ONE; end
                else if (b[0])  s <= 1'b0;
              end else begin
                if (b[11]) begin
                  ac_q[7:0] <= inpr;
                  fgi       <= 1'b0;
                end else if (b[10]) begin
                  outr <= ac_q[7:0];
                  fgo  <= 1'b0;
                end
                else if (b[9]) begin if (fgi) pc_q <= pc_q + A_ONE; end
                else if (b[8]) begin if (fgo) pc_q <= pc_q + A_ONE; end
                else if (b[7]) ien <= 1'b1;
                else if (b[6]) ien <= 1'b0;
              end
            end else begin
              case (t)
                T3: if (ind) ar <= mrd[ADDR_W-1:0];
                T4: begin
                  case (op)
                    3'd3: t <= T0;
                    3'd4: begin pc_q <= ar; t <= T0; end
                    3'd5: ar <= ar + A_ONE;
                    default: dr <= mrd;
                  endcase
                end
                T5: begin
                  t <= T0;
                  case (op)
                    3'd0: ac_q <= ac_q & dr;
                    3'd1: {e_q, ac_q} <= {1'b0, ac_q} + {1'b0, dr};
                    3'd2: ac_q <= dr;
                    3'd5: pc_q <= ar;
                    3'd6: begin dr <= dr + D_ONE; t <= T6; end
                    default: ;
                  endcase
                end
                default: begin
                  t <= T0;
                  if (op == 3'd6 && dr == '0) pc_q <= pc_q + A_ONE;
                end
              endcase
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mano_cpu_param.sv
// Bench for mano_cpu_param: directed programs plus random programs checked
// against an instruction-level model of the basic computer.
module tb_mano_cpu_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2;
  logic        run1, e1, run2, e2;
  logic [11:0] pc1;
  logic [15:0] ac1, ir1, pc2;
  logic [19:0] ac2, ir2;
  logic [3:0]  sc1, sc2;

  mano_cpu_param_if #(.ADDR_W(12), .MEM_AW(8))  bus1 ();
  mano_cpu_param_if #(.ADDR_W(16), .MEM_AW(10)) bus2 ();

  mano_cpu_param #(.ADDR_W(12), .MEM_AW(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .running(run1), .pc(pc1),
    .ac(ac1), .ir(ir1), .e(e1), .sc(sc1)
  );

  mano_cpu_param #(.ADDR_W(16), .MEM_AW(10)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .running(run2), .pc(pc2),
    .ac(ac2), .ir(ir2), .e(e2), .sc(sc2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model (ADDR_W=12, MEM_AW=8)
  logic [15:0] mm [256];
  logic [11:0] m_pc;
  logic [15:0] m_ac, m_ir;
  logic        m_e, m_ien, m_r, m_fgi, m_fgo, m_s;
  logic [7:0]  m_inpr, m_outr;

  function automatic void model_reset();
    m_pc = '0; m_ac = '0; m_ir = '0; m_e = 1'b0; m_ien = 1'b0; m_r = 1'b0;
    m_fgi = 1'b0; m_fgo = 1'b1; m_inpr = '0; m_outr = '0; m_s = 1'b0;
  endfunction

  // Executes one instruction (or interrupt cycle); returns its clock count.
  function automatic int model_step();
    logic [2:0]  op;
    logic        ind, irq;
    logic [11:0] a, ea;
    logic [15:0] md;
    logic [16:0] x;
    int          sum, cyc;
    if (m_r) begin
      mm[0] = {4'h0, m_pc};
      m_pc = 12'd1;
      m_ien = 1'b0;
      m_r = 1'b0;
      return 3;
    end
    m_ir = mm[m_pc[7:0]];
    m_pc = m_pc + 12'd1;
    ind = m_ir[15];
    op  = m_ir[14:12];
    a   = m_ir[11:0];
    irq = m_ien && (m_fgi || m_fgo);
    cyc = 4;
    if (op == 3'd7 && !ind) begin
      x = {m_e, m_ac};
      if (a[11]) m_ac = '0;
      else if (a[10]) m_e = 1'b0;
      else if (a[9]) m_ac = ~m_ac;
      else if (a[8]) m_e = ~m_e;
      else if (a[7]) begin x = {x[0], x[16:1]}; m_e = x[16]; m_ac = x[15:0]; end
      else if (a[6]) begin x = {x[15:0], x[16]}; m_e = x[16]; m_ac = x[15:0]; end
      else if (a[5]) m_ac = m_ac + 16'd1;
      else if (a[4]) begin if (!m_ac[15]) m_pc = m_pc + 12'd1; end
      else if (a[3]) begin if (m_ac[15]) m_pc = m_pc + 12'd1; end
      else if (a[2]) begin if (m_ac == 16'd0) m_pc = m_pc + 12'd1; end
      else if (a[1]) begin if (!m_e) m_pc = m_pc + 12'd1; end
      else if (a[0]) m_s = 1'b0;
    end else if (op == 3'd7) begin
      if (a[11]) begin m_ac[7:0] = m_inpr; m_fgi = 1'b0; end
      else if (a[10]) begin m_outr = m_ac[7:0]; m_fgo = 1'b0; end
      else if (a[9]) begin if (m_fgi) m_pc = m_pc + 12'd1; end
      else if (a[8]) begin if (m_fgo) m_pc = m_pc + 12'd1; end
      else if (a[7]) m_ien = 1'b1;
      else if (a[6]) m_ien = 1'b0;
    end else begin
      ea = ind ? mm[a[7:0]][11:0] : a;
      md = mm[ea[7:0]];
      case (op)
        3'd0: begin m_ac = m_ac & md; cyc = 6; end
        3'd1: begin
          sum = int'(m_ac) + int'(md);
          m_e = (sum > 65535);
          m_ac = sum[15:0];
          cyc = 6;
        end
        3'd2: begin m_ac = md; cyc = 6; end
        3'd3: begin mm[ea[7:0]] = m_ac; cyc = 5; end
        3'd4: begin m_pc = ea; cyc = 5; end
        3'd5: begin mm[ea[7:0]] = {4'h0, m_pc}; m_pc = ea + 12'd1; cyc = 6; end
        default: begin
          md = md + 16'd1;
          mm[ea[7:0]] = md;
          if (md == 16'd0) m_pc = m_pc + 12'd1;
          cyc = 7;
        end
      endcase
    end
    if (irq) m_r = 1'b1;
    return cyc;
  endfunction

  function automatic logic [15:0] rand_word();
    int k;
    logic [11:0] f;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), 12'($urandom)};
      4, 5, 6: begin
        k = $urandom_range(0, 11);
        f = 12'(1 << k);
        if ($urandom_range(0, 2) == 0) f = f | (12'($urandom) & (f - 12'd1));
        return {4'h7, f};
      end
      7: begin
        k = $urandom_range(6, 11);
        return {4'hF, 12'(1 << k)};
      end
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic reset1();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_mm();
    for (int i = 0; i < 256; i++) mm[i] = '0;
  endtask

  task automatic load1();
    for (int i = 0; i < 256; i++) begin
      bus1.mem_we = 1'b1;
      bus1.mem_addr = 8'(i);
      bus1.mem_wdata = mm[i];
      tick();
    end
    bus1.mem_we = 1'b0;
  endtask

  task automatic offer_input(input logic [7:0] ch);
    bus1.in_data = ch;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    if (!m_fgi) begin m_inpr = ch; m_fgi = 1'b1; end
    chk("in_ready", bus1.in_ready, !m_fgi);
  endtask

  task automatic run_prog(input string name, input int budget);
    int total = 0;
    m_s = 1'b1;
    while (m_s && total < budget) total += model_step();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    repeat (total) tick();
    chk({name, "_pc"}, pc1, m_pc);
    chk({name, "_ac"}, ac1, m_ac);
    chk({name, "_e"}, e1, m_e);
    chk({name, "_ir"}, ir1, m_ir);
    chk({name, "_sc"}, sc1, 0);
    chk({name, "_running"}, run1, m_s);
    chk({name, "_in_ready"}, bus1.in_ready, !m_fgi);
    chk({name, "_out_valid"}, bus1.out_valid, !m_fgo);
    chk({name, "_out_data"}, bus1.out_data, m_outr);
    if (m_s) reset1();
    for (int i = 0; i < 256; i++) begin
      bus1.mem_addr = 8'(i);
      #1;
      chk($sformatf("%s_mem[%0h]", name, i), bus1.mem_rdata, mm[i]);
    end
  endtask

  task automatic load2(input logic [9:0] addr, input logic [19:0] data);
    bus2.mem_we = 1'b1;
    bus2.mem_addr = addr;
    bus2.mem_wdata = data;
    tick();
    bus2.mem_we = 1'b0;
  endtask

  initial begin
    logic found;
    bus1.start = 0; bus1.mem_we = 0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    bus1.in_data = '0; bus1.in_valid = 0; bus1.out_ready = 0;
    bus2.start = 0; bus2.mem_we = 0; bus2.mem_addr = '0; bus2.mem_wdata = '0;
    bus2.in_data = '0; bus2.in_valid = 0; bus2.out_ready = 0;
    rst = 1'b1; rst2 = 1'b1;
    tick(); tick();
    rst = 1'b0; rst2 = 1'b0;
    model_reset();

    chk("rst_pc", pc1, 0);
    chk("rst_ac", ac1, 0);
    chk("rst_ir", ir1, 0);
    chk("rst_e", e1, 0);
    chk("rst_sc", sc1, 0);
    chk("rst_running", run1, 0);
    chk("rst_in_ready", bus1.in_ready, 1);
    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_out_data", bus1.out_data, 0);

    // LDA/ADD/STA/HLT
    reset1(); clear_mm();
    mm[0] = 16'h2004; mm[1] = 16'h1005; mm[2] = 16'h3006; mm[3] = 16'h7001;
    mm[4] = 16'h0007; mm[5] = 16'h0009;
    load1(); run_prog("basic", 200);
    chk("basic_ac_const", ac1, 16'h0010);
    chk("basic_pc_const", pc1, 12'd4);

    // ISZ loop
    reset1(); clear_mm();
    mm[0] = 16'h6005; mm[1] = 16'h4000; mm[2] = 16'h7001; mm[3] = 16'h7001;
    mm[5] = 16'hFFFE;
    load1(); run_prog("isz", 200);
    chk("isz_pc_const", pc1, 12'd3);

    // BSA then indirect BUN return
    reset1(); clear_mm();
    mm[0] = 16'h5010; mm[1] = 16'h7001; mm[16] = 16'h0000; mm[17] = 16'hC010;
    load1(); run_prog("bsa", 200);
    chk("bsa_pc_const", pc1, 12'd2);

    // Indirect ADD, without and with carry
    reset1(); clear_mm();
    mm[0] = 16'h2010; mm[1] = 16'h9008; mm[2] = 16'h3012; mm[3] = 16'h2011;
    mm[4] = 16'h9008; mm[5] = 16'h7001; mm[8] = 16'h0009; mm[9] = 16'h0001;
    mm[16] = 16'h7FFF; mm[17] = 16'hFFFF;
    load1(); run_prog("addc", 200);
    chk("addc_ac_const", ac1, 16'h0000);
    chk("addc_e_const", e1, 1);

    // Register-reference rotates/complement/increment
    reset1(); clear_mm();
    mm[0] = 16'h2010; mm[1] = 16'h7040; mm[2] = 16'h7080; mm[3] = 16'h7200;
    mm[4] = 16'h7020; mm[5] = 16'h7001; mm[16] = 16'h8001;
    load1(); run_prog("regref", 200);

    // Interrupt taken during INP, return address saved in M[0]
    reset1(); clear_mm();
    mm[0] = 16'hF080; mm[1] = 16'hF800; mm[2] = 16'h7001;
    load1(); offer_input(8'h41); run_prog("intr", 200);
    chk("intr_ac_const", ac1, 16'h0041);

    // OUT then consumer handshake
    reset1(); clear_mm();
    mm[0] = 16'h2005; mm[1] = 16'hF400; mm[2] = 16'h7001; mm[5] = 16'h1234;
    load1(); run_prog("out", 200);
    chk("out_data_const", bus1.out_data, 8'h34);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    m_fgo = 1'b1;
    chk("out_accepted", bus1.out_valid, !m_fgo);

    // Random programs
    for (int n = 0; n < 12; n++) begin
      reset1();
      for (int i = 0; i < 256; i++) mm[i] = rand_word();
      load1();
      if ($urandom_range(0, 1) == 1) offer_input(8'($urandom));
      run_prog($sformatf("rnd%0d", n), 400);
    end

    // Reset in the middle of ISZ (T5): no write, all state back to reset
    reset1(); clear_mm();
    mm[0] = 16'h6005; mm[1] = 16'h4000; mm[2] = 16'h7001; mm[5] = 16'hFFFE;
    load1();
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (sc1 == 4'd5) found = 1'b1;
    end
    chk("midisz_t5_reached", found, 1);
    rst = 1'b1;
    tick();
    chk("midisz_pc", pc1, 0);
    chk("midisz_ac", ac1, 0);
    chk("midisz_ir", ir1, 0);
    chk("midisz_e", e1, 0);
    chk("midisz_sc", sc1, 0);
    chk("midisz_running", run1, 0);
    chk("midisz_out_valid", bus1.out_valid, 0);
    rst = 1'b0;
    model_reset();
    bus1.mem_addr = 8'd5; #1;
    chk("midisz_mem5", bus1.mem_rdata, 16'hFFFE);
    bus1.mem_addr = 8'd0; #1;
    chk("midisz_mem0", bus1.mem_rdata, 16'h6005);

    // Wide build: ADDR_W=16, MEM_AW=10, HLT is bit 4 of the address field
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    load2(10'h000, 20'h20204); load2(10'h001, 20'h10205);
    load2(10'h002, 20'h30206); load2(10'h003, 20'h70010);
    load2(10'h204, 20'h80007); load2(10'h205, 20'h80009); load2(10'h206, 20'h00000);
    bus2.start = 1'b1; tick(); bus2.start = 1'b0;
    for (int k = 0; k < 60 && run2; k++) tick();
    chk("wide_halted", run2, 0);
    chk("wide_ac", ac2, 20'h00010);
    chk("wide_e", e2, 1);
    chk("wide_pc", pc2, 16'h0004);
    chk("wide_ir", ir2, 20'h70010);
    chk("wide_sc", sc2, 0);
    bus2.mem_addr = 10'h206; #1;
    chk("wide_mem206", bus2.mem_rdata, 20'h00010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
